carpma_birimi: RTL and testbench

CARPMA_BIRIMI -- requirements
Module: carpma_birimi

---
 rtl/carpma_birimi.sv | 145 ++++++++++++++
 tb/tb_carpma_birimi.sv | 162 ++++++++++++++++
 2 files changed

// File: rtl/carpma_birimi.sv
// Iterative radix-4 RV32M multiplier (MUL/MULH/MULHSU/MULHU); CARPMA_ERKEN_BITIS_EN enables zero-operand early finish.
// Latency 18 cycles (2 with early finish); basla_i is held until bitti_o is seen, dropping it aborts.
`timescale 1ns/1ps
module carpma_birimi (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        basla_i,
  input  logic [1:0]  islem_i,
  input  logic [31:0] carpilan_i,
  input  logic [31:0] carpan_i,
  output logic [31:0] sonuc_o,
  output logic        bitti_o
);

  localparam logic [1:0] ISLEM_MUL    = 2'b00;
  localparam logic [1:0] ISLEM_MULH   = 2'b01;
  localparam logic [1:0] ISLEM_MULHSU = 2'b10;
  localparam logic [1:0] ISLEM_MULHU  = 2'b11;

  typedef enum logic [1:0] {
    YUKLE = 2'b00,
    CARP  = 2'b01,
    SONUC = 2'b10
  } durum_t;

  durum_t      durum_q, durum_d;
  logic [3:0]  sayac_q;
  logic [63:0] carpilan_q;
  logic [31:0] carpan_q;
  logic [63:0] birikim_q;
  logic        isaret_q;
  logic        dusuk_q;

  logic        a_isaretli, b_isaretli;
  logic        a_neg, b_neg;
  logic [31:0] a_mag, b_mag;
  logic        sifir;
  logic [63:0] kismi;
  logic [63:0] carpim;

  // Operand decode; magnitude of 0x80000000 is 2^31 and still fits in 32 bits.
  always_comb begin
    a_isaretli = (islem_i != ISLEM_MULHU);
    b_isaretli = (islem_i == ISLEM_MUL) || (islem_i == ISLEM_MULH);
    a_neg      = a_isaretli && carpilan_i[31];
    b_neg      = b_isaretli && carpan_i[31];
    a_mag      = a_neg ? (~carpilan_i + 32'd1) : carpilan_i;
    b_mag      = b_neg ? (~carpan_i + 32'd1) : carpan_i;
    sifir      = (carpilan_i == 32'd0) || (carpan_i == 32'd0);
  end

  always_comb begin
    case (carpan_q[1:0])
      2'b00:   kismi = 64'd0;
      2'b01:   kismi = carpilan_q;
      2'b10:   kismi = {carpilan_q[62:0], 1'b0};
      default: kismi = carpilan_q + {carpilan_q[62:0], 1'b0};
    endcase
    carpim = isaret_q ? (~birikim_q + 64'd1) : birikim_q;
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      durum_q <= YUKLE;
    end else begin
      durum_q <= durum_d;
    end
  end

  always_comb begin
    durum_d = YUKLE;
    bitti_o = 1'b1;
    sonuc_o = 32'd0;
    if (basla_i) begin
      case (durum_q)
        YUKLE: begin
          bitti_o = 1'b0;
`ifdef CARPMA_ERKEN_BITIS_EN
          durum_d = sifir ? SONUC : CARP;
`else
          durum_d = CARP;
`endif
        end
        CARP: begin
          bitti_o = 1'b0;
          durum_d = (sayac_q == 4'd15) ? SONUC : CARP;
        end
        SONUC: begin
          bitti_o = 1'b1;
          sonuc_o = dusuk_q ? carpim[31:0] : carpim[63:32];
          durum_d = YUKLE;
        end
        default: begin
          bitti_o = 1'b0;
          durum_d = YUKLE;
        end
      endcase
    end
  end

  // Datapath: a dropped request clears everything so the next start is clean.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      sayac_q    <= 4'd0;
      carpilan_q <= 64'd0;
      carpan_q   <= 32'd0;
      birikim_q  <= 64'd0;
      isaret_q   <= 1'b0;
      dusuk_q    <= 1'b0;
    end else if (!basla_i) begin
      sayac_q    <= 4'd0;
      carpilan_q <= 64'd0;
      carpan_q   <= 32'd0;
      birikim_q  <= 64'd0;
      isaret_q   <= 1'b0;
      dusuk_q    <= 1'b0;
    end else begin
      case (durum_q)
        YUKLE: begin
          sayac_q    <= 4'd0;
          carpilan_q <= {32'd0, a_mag};
          carpan_q   <= b_mag;
          birikim_q  <= 64'd0;
          isaret_q   <= (a_neg ^ b_neg) && !sifir;
          dusuk_q    <= (islem_i == ISLEM_MUL);
        end
        CARP: begin
          sayac_q    <= sayac_q + 4'd1;
          birikim_q  <= birikim_q + kismi;
          carpilan_q <= {carpilan_q[61:0], 2'b00};
          carpan_q   <= {2'b00, carpan_q[31:2]};
        end
        default: begin
          sayac_q    <= 4'd0;
          carpilan_q <= 64'd0;
          carpan_q   <= 32'd0;
          birikim_q  <= 64'd0;
          isaret_q   <= 1'b0;
          dusuk_q    <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_carpma_birimi.sv
// Directed bench for carpma_birimi: latency, signedness per operation, abort, reset and back-to-back.
`timescale 1ns/1ps
module tb_carpma_birimi;

  logic        clk_i;
  logic        rst_i;
  logic        basla_i;
  logic [1:0]  islem_i;
  logic [31:0] carpilan_i;
  logic [31:0] carpan_i;
  logic [31:0] sonuc_o;
  logic        bitti_o;

  int toplam = 0;
  int gecen  = 0;
  int sifir_gecikme;

  carpma_birimi dut (
    .clk_i      (clk_i),
    .rst_i      (rst_i),
    .basla_i    (basla_i),
    .islem_i    (islem_i),
    .carpilan_i (carpilan_i),
    .carpan_i   (carpan_i),
    .sonuc_o    (sonuc_o),
    .bitti_o    (bitti_o)
  );

  initial clk_i = 1'b0;
  always #5 clk_i = ~clk_i;

  task automatic chk(input string etiket, input logic [31:0] gozlenen, input logic [31:0] beklenen);
    toplam++;
    assert (gozlenen === beklenen) gecen++;
    else $error("FAIL %s: got 0x%08h, want 0x%08h", etiket, gozlenen, beklenen);
  endtask

  // Current cycle counts as cycle 1; samples 1 time unit into each cycle.
  task automatic bekle_bitti(input int gecikme, input logic [31:0] beklenen, input string etiket,
                             input bit karistir);
    int ilk = 0;
    for (int c = 1; c <= 40 && ilk == 0; c++) begin
      #1;
      if (bitti_o === 1'b1) begin
        ilk = c;
      end else begin
        if (karistir && c == 5) begin
          islem_i    = 2'b00;
          carpilan_i = 32'h0000_0001;
          carpan_i   = 32'h0000_0001;
        end
        @(negedge clk_i);
      end
    end
    chk({etiket, "_gecikme"}, ilk, gecikme);
    chk({etiket, "_sonuc"}, sonuc_o, beklenen);
  endtask

  task automatic islem_yap(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                           input int gecikme, input logic [31:0] beklenen, input string etiket,
                           input bit karistir);
    @(negedge clk_i);
    islem_i    = op;
    carpilan_i = a;
    carpan_i   = b;
    basla_i    = 1'b1;
    bekle_bitti(gecikme, beklenen, etiket, karistir);
  endtask

  task automatic birak();
    @(negedge clk_i);
    basla_i = 1'b0;
  endtask

  initial begin
`ifdef CARPMA_ERKEN_BITIS_EN
    sifir_gecikme = 2;
`else
    sifir_gecikme = 18;
`endif
    rst_i      = 1'b1;
    basla_i    = 1'b0;
    islem_i    = 2'b00;
    carpilan_i = 32'd0;
    carpan_i   = 32'd0;

    #1;
    chk("reset_bitti", {31'd0, bitti_o}, 32'd1);
    chk("reset_sonuc", sonuc_o, 32'd0);
    @(negedge clk_i);
    rst_i = 1'b0;
    @(negedge clk_i);
    #1;
    chk("bos_bitti", {31'd0, bitti_o}, 32'd1);
    chk("bos_sonuc", sonuc_o, 32'd0);

    islem_yap(2'b00, 32'd7, 32'd6, 18, 32'h0000_002A, "mul_7x6", 1'b0);
    birak();

    islem_yap(2'b00, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 18, 32'h0000_0001, "mul_m1", 1'b0);
    birak();
    islem_yap(2'b01, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 18, 32'h0000_0000, "mulh_m1", 1'b0);
    birak();
    islem_yap(2'b10, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 18, 32'hFFFF_FFFF, "mulhsu_m1", 1'b0);
    birak();
    islem_yap(2'b11, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 18, 32'hFFFF_FFFE, "mulhu_m1", 1'b0);
    birak();

    islem_yap(2'b01, 32'h8000_0000, 32'h8000_0000, 18, 32'h4000_0000, "mulh_min", 1'b0);
    birak();
    islem_yap(2'b00, 32'h8000_0000, 32'h8000_0000, 18, 32'h0000_0000, "mul_min", 1'b0);
    birak();

    islem_yap(2'b00, 32'hFFFF_FFFE, 32'd3, 18, 32'hFFFF_FFFA, "mul_neg", 1'b0);
    birak();
    islem_yap(2'b01, 32'hFFFF_FFFE, 32'd3, 18, 32'hFFFF_FFFF, "mulh_neg", 1'b0);
    birak();

    // Operands and op change mid-CARP must not leak into the result.
    islem_yap(2'b10, 32'hFFFF_FFFE, 32'h8000_0000, 18, 32'hFFFF_FFFF, "mulhsu_karistir", 1'b1);
    birak();

    // Abort: request dropped in cycle 8, then a fresh request.
    @(negedge clk_i);
    islem_i    = 2'b00;
    carpilan_i = 32'd3;
    carpan_i   = 32'd5;
    basla_i    = 1'b1;
    repeat (7) @(negedge clk_i);
    basla_i = 1'b0;
    #1;
    chk("iptal_bitti", {31'd0, bitti_o}, 32'd1);
    chk("iptal_sonuc", sonuc_o, 32'd0);
    islem_yap(2'b00, 32'd2, 32'd9, 18, 32'h0000_0012, "iptal_sonra", 1'b0);

    // Back-to-back: request stays high through SONUC.
    islem_yap(2'b11, 32'h0001_0000, 32'h0001_0000, 18, 32'h0000_0001, "ardisik", 1'b0);
    birak();

    // Asynchronous reset pulse mid-CARP with request held.
    @(negedge clk_i);
    islem_i    = 2'b11;
    carpilan_i = 32'h0001_0000;
    carpan_i   = 32'h0001_0000;
    basla_i    = 1'b1;
    repeat (6) @(negedge clk_i);
    #1 rst_i = 1'b1;
    #0.5;
    chk("rst_ortasi_bitti", {31'd0, bitti_o}, 32'd0);
    #0.5 rst_i = 1'b0;
    bekle_bitti(18, 32'h0000_0001, "rst_sonra", 1'b0);
    birak();

    islem_yap(2'b00, 32'd0, 32'h0000_1234, sifir_gecikme, 32'h0000_0000, "sifir", 1'b0);
    birak();

    @(negedge clk_i);
    $display("%0d/%0d checks passed", gecen, toplam);
    $finish;
  end

endmodule
